// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the set-associative cache hit/miss model.
//   - DEF_*        : default geometry, also used as module parameter defaults
//   - way_width()  : width of a way number (at least 1 bit, even for 1 way)
//   - DEF_*_W      : address-field widths derived from the default geometry
//   - set_state_t  : per-set valid/tag/age state for the default geometry
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_NUM_SETS    = 64;
  localparam int DEF_NUM_WAYS    = 4;

  // A direct-mapped cache still needs a 1-bit way field on its ports.
  function automatic int way_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  localparam int DEF_OFFSET_W = $clog2(DEF_BLOCK_BYTES);
  localparam int DEF_INDEX_W  = $clog2(DEF_NUM_SETS);
  localparam int DEF_WAY_W    = way_width(DEF_NUM_WAYS);
  localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

  typedef struct packed {
    logic [DEF_NUM_WAYS-1:0]                valid;
    logic [DEF_NUM_WAYS-1:0][DEF_TAG_W-1:0] tag;
    logic [DEF_NUM_WAYS-1:0][DEF_WAY_W-1:0] age;
  } set_state_t;

endpackage

// File: rtl/lru_age_update.sv
// ----------------------------------------------------------------------------
// lru_age_update
//   Combinational true-LRU helper for one set.
//   ages_i   : current age of each way (0 = most recent)
//   valid_i  : valid bit of each way
//   way_i    : way being accessed this cycle (hit way or fill victim)
//   ages_o   : ages after the access to way_i
//   victim_o : way to fill on a miss (lowest invalid way, else the oldest)
// ----------------------------------------------------------------------------
module lru_age_update #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages_i,
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]               way_i,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] ages_o,
  output logic [WAY_W-1:0]               victim_o
);

  logic             found_invalid;
  logic [WAY_W-1:0] acc_age;

  // Victim selection does not depend on way_i, so it lives in its own
  // process; the parent feeds victim_o back in as way_i on a miss.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no
    // path leaves it unassigned, which would otherwise infer a latch.
    victim_o      = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !found_invalid) begin
        victim_o      = WAY_W'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ages_i[w] == WAY_W'(NUM_WAYS - 1)) victim_o = WAY_W'(w);
      end
    end
  end

  // Ways younger than the accessed one age by one; the accessed way becomes
  // the youngest. This keeps the ages a permutation of 0..NUM_WAYS-1.
  always_comb begin
    acc_age = ages_i[way_i];
    ages_o  = ages_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way_i)       ages_o[w] = '0;
      else if (ages_i[w] < acc_age) ages_o[w] = ages_i[w] + 1'b1;
    end
  end

endmodule

// File: rtl/sa_cache_model.sv
// ----------------------------------------------------------------------------
// sa_cache_model
//   Trace-driven N-way set-associative cache hit/miss model, true LRU.
//   Tag/valid/age state only, held in flops so a flush takes one cycle.
//   clk, rst_n            : clock, synchronous active-low reset
//   addr_valid/addr_ready : request handshake; addr_ready = ~flush
//   addr                  : byte address to look up
//   flush                 : invalidate every line at the next edge
//   resp_valid            : one-cycle pulse, one cycle after an accept
//   resp_hit, resp_way    : result of the last accepted request (held)
//   hitCount, missCount   : saturating totals since reset
// ----------------------------------------------------------------------------
module sa_cache_model
  import cache_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int NUM_SETS    = DEF_NUM_SETS,
  parameter int NUM_WAYS    = DEF_NUM_WAYS,
  parameter int CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           addr_valid,
  input  logic [ADDR_W-1:0]              addr,
  output logic                           addr_ready,
  input  logic                           flush,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [way_width(NUM_WAYS)-1:0] resp_way,
  output logic [CNT_W-1:0]               hitCount,
  output logic [CNT_W-1:0]               missCount
);

  localparam int OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int SET_W    = (INDEX_W > 0) ? INDEX_W : 1;
  localparam int WAY_W    = way_width(NUM_WAYS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_W-1:0] tag_q   [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q   [NUM_SETS];

  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q,   resp_hit_d;
  logic [WAY_W-1:0] resp_way_q,   resp_way_d;
  logic [CNT_W-1:0] hit_cnt_q,    hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

  logic [SET_W-1:0]               set_idx;
  logic [TAG_W-1:0]               tag;
  logic                           accept;
  logic                           hit;
  logic [WAY_W-1:0]               hit_way;
  logic [WAY_W-1:0]               victim;
  logic [WAY_W-1:0]               acc_way;
  logic [NUM_WAYS-1:0][WAY_W-1:0] new_ages;

  // Address split: offset bits select a byte inside the line and are ignored.
  if (INDEX_W > 0) begin : g_index
    assign set_idx = addr[OFFSET_W +: INDEX_W];
  end else begin : g_no_index
    assign set_idx = '0;
  end
  if (OFFSET_W > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^addr[OFFSET_W-1:0];
  end
  assign tag = addr[ADDR_W-1 -: TAG_W];

  assign addr_ready = ~flush;
  assign accept     = addr_valid && !flush;

  // Tags are only written on a fill, so at most one valid way can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign acc_way = hit ? hit_way : victim;

  lru_age_update #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_lru (
    .ages_i   (age_q[set_idx]),
    .valid_i  (valid_q[set_idx]),
    .way_i    (acc_way),
    .ages_o   (new_ages),
    .victim_o (victim)
  );

  // Response and saturating counters; hit/way hold when nothing is accepted.
  always_comb begin
    resp_valid_d = accept;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (accept) begin
      resp_hit_d = hit;
      resp_way_d = acc_way;
      if (hit && !(&hit_cnt_q))    hit_cnt_d  = hit_cnt_q + 1'b1;
      if (!hit && !(&miss_cnt_q))  miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end else if (accept) begin
        valid_q[set_idx][acc_way] <= 1'b1;
        age_q[set_idx]            <= new_ages;
      end
    end
  end

  // NOTE: the tag array is deliberately left out of reset; a tag is never
  // compared while its valid bit is clear, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (rst_n && accept && !hit) tag_q[set_idx][victim] <= tag;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign hitCount   = hit_cnt_q;
  assign missCount  = miss_cnt_q;

endmodule

// File: tb/tb_sa_cache_model.sv
// ----------------------------------------------------------------------------
// tb_sa_cache_model
//   Two instances share one stimulus: default geometry with CNT_W=32 and
//   CNT_W=4. A reference model keeps, per set, way tags/valids and a recency
//   list of ways (front = most recent); a compare process checks both DUTs
//   against it on every falling edge. Directed sequences add literal checks.
// ----------------------------------------------------------------------------
module tb_sa_cache_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addr_valid = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;

  logic        ready_a, rv_a, rh_a;
  logic [1:0]  rw_a;
  logic [31:0] hc_a, mc_a;
  logic        ready_b, rv_b, rh_b;
  logic [1:0]  rw_b;
  logic [3:0]  hc_b, mc_b;

  always #5 clk = ~clk;

  sa_cache_model u_dut (
    .clk (clk), .rst_n (rst_n), .addr_valid (addr_valid), .addr (addr),
    .addr_ready (ready_a), .flush (flush), .resp_valid (rv_a),
    .resp_hit (rh_a), .resp_way (rw_a), .hitCount (hc_a), .missCount (mc_a)
  );

  sa_cache_model #(.CNT_W(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .addr_valid (addr_valid), .addr (addr),
    .addr_ready (ready_b), .flush (flush), .resp_valid (rv_b),
    .resp_hit (rh_b), .resp_way (rw_b), .hitCount (hc_b), .missCount (mc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (default geometry) ----------------
  bit          mv  [64][4];
  logic [21:0] mt  [64][4];
  int          rec [64][$];
  longint      m_hits, m_miss;
  bit          exp_valid, exp_hit;
  int          exp_way;
  bit          chk_en = 1'b0;

  function automatic logic [63:0] sat(input longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (c > mx) ? 64'(mx) : 64'(c);
  endfunction

  // Applies the effect of the edge that just sampled (v, a, f, r).
  task automatic model_step(input logic v, input logic [31:0] a, input logic f, input logic r);
    int s, way, pos;
    logic [21:0] t;
    bit h;
    if (!r) begin
      for (int i = 0; i < 64; i++) begin
        rec[i].delete();
        for (int w = 0; w < 4; w++) begin
          mv[i][w] = 1'b0;
          rec[i].push_back(w);
        end
      end
      m_hits = 0; m_miss = 0;
      exp_valid = 1'b0; exp_hit = 1'b0; exp_way = 0;
      return;
    end
    exp_valid = 1'b0;
    if (f) begin
      for (int i = 0; i < 64; i++)
        for (int w = 0; w < 4; w++) mv[i][w] = 1'b0;
      return;
    end
    if (!v) return;
    s = int'(a[9:4]);
    t = a[31:10];
    h = 1'b0; way = -1;
    for (int w = 0; w < 4; w++)
      if (mv[s][w] && mt[s][w] == t) begin h = 1'b1; way = w; end
    if (!h) begin
      for (int w = 3; w >= 0; w--) if (!mv[s][w]) way = w;
      if (way < 0) way = rec[s][rec[s].size()-1];
      mv[s][way] = 1'b1;
      mt[s][way] = t;
      m_miss++;
    end else begin
      m_hits++;
    end
    pos = 0;
    for (int i = 0; i < rec[s].size(); i++) if (rec[s][i] == way) pos = i;
    rec[s].delete(pos);
    rec[s].push_front(way);
    exp_valid = 1'b1; exp_hit = h; exp_way = way;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("addr_ready",   64'(ready_a), 64'(!flush));
      check("addr_ready4",  64'(ready_b), 64'(!flush));
      check("resp_valid",   64'(rv_a), 64'(exp_valid));
      check("resp_valid4",  64'(rv_b), 64'(exp_valid));
      check("resp_hit",     64'(rh_a), 64'(exp_hit));
      check("resp_hit4",    64'(rh_b), 64'(exp_hit));
      check("resp_way",     64'(rw_a), 64'(exp_way));
      check("resp_way4",    64'(rw_b), 64'(exp_way));
      check("hitCount",     64'(hc_a), sat(m_hits, 32));
      check("missCount",    64'(mc_a), sat(m_miss, 32));
      check("hitCount4",    64'(hc_b), sat(m_hits, 4));
      check("missCount4",   64'(mc_b), sat(m_miss, 4));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic f, input logic r);
    addr_valid = v; addr = a; flush = f; rst_n = r;
  endtask

  task automatic tick();
    logic v, f, r;
    logic [31:0] a;
    v = addr_valid; a = addr; f = flush; r = rst_n;
    @(posedge clk);
    #1;
    model_step(v, a, f, r);
  endtask

  task automatic acc(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b1); tick();
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst resp_valid", 64'(rv_a), 64'd0);
    check("rst hitCount",   64'(hc_a), 64'd0);

    // 1: miss then hit in the same line
    acc(32'h0000_0000);
    check("t1 first hit", 64'(rh_a), 64'd0);
    check("t1 first way", 64'(rw_a), 64'd0);
    acc(32'h0000_0004);
    check("t1 second hit", 64'(rh_a), 64'd1);
    check("t1 hitCount",   64'(hc_a), 64'd1);
    check("t1 missCount",  64'(mc_a), 64'd1);
    idle();
    check("t1 idle valid", 64'(rv_a), 64'd0);
    check("t1 idle hold",  64'(rh_a), 64'd1);

    // 2: five tags into set 0, LRU eviction then refill of evicted line
    do_reset();
    acc(32'h000); acc(32'h400); acc(32'h800); acc(32'hC00);
    acc(32'h1000);
    check("t2 0x1000 way", 64'(rw_a), 64'd0);
    acc(32'h000);
    check("t2 0x000 hit", 64'(rh_a), 64'd0);
    check("t2 0x000 way", 64'(rw_a), 64'd1);
    check("t2 missCount", 64'(mc_a), 64'd6);

    // 3: a hit refreshes 0x000, so 0x400 becomes the victim
    do_reset();
    acc(32'h000); acc(32'h400); acc(32'h800); acc(32'hC00);
    acc(32'h000);
    check("t3 0x000 hit", 64'(rh_a), 64'd1);
    acc(32'h1000);
    check("t3 0x1000 way", 64'(rw_a), 64'd1);
    acc(32'h400);
    check("t3 0x400 hit", 64'(rh_a), 64'd0);
    check("t3 0x400 way", 64'(rw_a), 64'd2);
    acc(32'h000);
    check("t3 0x000 hit2", 64'(rh_a), 64'd1);
    check("t3 0x000 way2", 64'(rw_a), 64'd0);
    check("t3 hitCount",  64'(hc_a), 64'd2);
    check("t3 missCount", 64'(mc_a), 64'd6);

    // other set index: same line hit, same-set different tag fills way 1
    acc(32'h1234); acc(32'h1238);
    check("set23 hit", 64'(rh_a), 64'd1);
    acc(32'h1634);
    check("set23 way", 64'(rw_a), 64'd1);

    // 4: flush with a concurrent request
    do_reset();
    acc(32'h000);
    drive(1'b1, 32'h000, 1'b1, 1'b1);
    #2;
    check("t4 ready", 64'(ready_a), 64'd0);
    tick();
    check("t4 no resp",   64'(rv_a), 64'd0);
    check("t4 missCount", 64'(mc_a), 64'd1);
    acc(32'h000);
    check("t4 retry hit", 64'(rh_a), 64'd0);
    check("t4 retry way", 64'(rw_a), 64'd0);
    check("t4 missCount2", 64'(mc_a), 64'd2);

    // 5: saturation of the 4-bit counter
    do_reset();
    acc(32'h000);
    for (int i = 0; i < 20; i++) acc(32'h000);
    check("t5 hitCount4",  64'(hc_b), 64'd15);
    check("t5 hitCount32", 64'(hc_a), 64'd20);
    check("t5 missCount4", 64'(mc_b), 64'd1);

    // 6: reset right after an accept drops nothing visible afterwards
    do_reset();
    acc(32'h000);
    acc(32'h000);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("t6 resp_valid", 64'(rv_a), 64'd0);
    check("t6 resp_hit",   64'(rh_a), 64'd0);
    check("t6 hitCount",   64'(hc_a), 64'd0);
    check("t6 missCount",  64'(mc_a), 64'd0);
    acc(32'h000);
    check("t6 miss again", 64'(rh_a), 64'd0);
    check("t6 missCount2", 64'(mc_a), 64'd1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
